// File: rtl/booth2_seq_mult.sv
// ---------------------------------------------------------------------------
// booth2_seq_mult
//
// Sequential radix-4 Booth multiplier for signed two's-complement operands.
// Each clock retires one Booth digit. The digit's partial product is
// accumulated into a 2*WIDTH-bit register. Valid/ready handshakes sit on both
// the operand side and the product side.
//
// Handshake rule (both sides): a transfer happens on the rising edge where
// valid and ready are both high. A producer holds valid and its data until
// that edge. in_ready is high only in IDLE. out_valid is high only in DONE,
// and product/out_valid stay stable until the out_valid & out_ready edge.
//
// Optional feature macro: BOOTH_SEQ_EARLY_TERM_EN
//   When it is defined, RUN ends early once every remaining multiplier bit
//   matches. All remaining digits are then zero, so the result is unchanged.
//
// Ports
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   in_valid   in   a/b are valid
//   in_ready   out  operands accepted (IDLE only)
//   a          in   WIDTH   multiplicand, signed
//   b          in   WIDTH   multiplier, signed
//   out_valid  out  product valid (DONE only)
//   out_ready  in   consumer accepts product
//   product    out  2*WIDTH signed a*b (zero outside DONE)
//   dbg_state  out  2       FSM state: 0 IDLE, 1 RUN, 2 DONE
// ---------------------------------------------------------------------------
module booth2_seq_mult #(
   parameter int WIDTH = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic [1:0]           dbg_state
);

   localparam int PW   = WIDTH + 2;      // partial-product width, holds +-2A exactly
   localparam int AW   = 2 * WIDTH;      // accumulator width
   localparam int NDIG = WIDTH / 2;      // Booth digits per operand
   localparam int CW   = $clog2(NDIG);   // digit counter width
   localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_q;
   // Multiplier with b[-1]=0 appended below the LSB. It is shifted right
   // arithmetically by two each digit, so bits [2:0] are always the current
   // Booth triplet.
   logic [WIDTH:0]   b_sh;
   logic [AW-1:0]    acc;
   logic [CW-1:0]    cnt;

   logic [PW-1:0]    a_ext;
   logic [PW-1:0]    pp;
   logic [AW-1:0]    pp_sh;
   logic             early_term;

   assign a_ext = {{2{a_q[WIDTH-1]}}, a_q};

   always_comb begin
      pp = '0;
      unique case (b_sh[2:0])
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_ext << 1;
         3'b100:         pp = -(a_ext << 1);
         3'b101, 3'b110: pp = -a_ext;
         default:        pp = '0;
      endcase
   end

   // Sign-extend the partial product to full width, then weight it by 4^i.
   assign pp_sh = {{(AW-PW){pp[PW-1]}}, pp} << {cnt, 1'b0};

   // The arithmetic shift fills the upper bits with copies of the sign. So all
   // remaining bits b[WIDTH-1:2i-1] are identical exactly when b_sh is all
   // zeros or all ones.
`ifdef BOOTH_SEQ_EARLY_TERM_EN
   assign early_term = (b_sh == '0) || (&b_sh);
`else
   assign early_term = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= S_IDLE;
         a_q   <= '0;
         b_sh  <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_sh  <= {b, 1'b0};
                  acc   <= '0;
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (early_term) begin
                  state <= S_DONE;
               end else begin
                  acc  <= acc + pp_sh;
                  b_sh <= {b_sh[WIDTH], b_sh[WIDTH], b_sh[WIDTH:2]};
                  cnt  <= cnt + 1'b1;
                  if (cnt == LAST_DIG) state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from registers only. product is masked outside DONE,
   // so a partial accumulation is never visible.
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign product   = (state == S_DONE) ? acc : '0;
   assign dbg_state = state;

endmodule

// File: tb/tb_booth2_seq_mult.sv
module tb_booth2_seq_mult;

   localparam int W = 16;

`ifdef BOOTH_SEQ_EARLY_TERM_EN
   localparam int LAT_FULL = -1;   // data dependent, not checked
   localparam int LAT_B0   = 1;
   localparam int LAT_BM1  = 2;
`else
   localparam int LAT_FULL = 8;
   localparam int LAT_B0   = 8;
   localparam int LAT_BM1  = 8;
`endif

   logic           sys_clk;
   logic           sys_rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] product;
   logic [1:0]     dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   booth2_seq_mult #(.WIDTH(W)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      check({tag, " in_ready_wait"}, 64'(in_ready), 64'd1);
   endtask

   // Present one operand pair, then wait for out_valid. This leaves the DUT
   // in DONE. Latency is checked only when exp_lat > 0.
   task automatic run_mult(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [2*W-1:0] exp, input int exp_lat);
      int lat;
      wait_ready(tag);
      a = av; b = bv; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom);
      check({tag, " in_ready_after_accept"}, 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      check({tag, " out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " in_ready_in_done"}, 64'(in_ready), 64'd0);
      if (exp_lat > 0) check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " product"}, 64'(product), 64'(exp));
   endtask

   // Release the product and confirm the return to IDLE.
   task automatic take_output(input string tag);
      out_ready = 1'b1;
      step();
      check({tag, " out_valid_after_take"}, 64'(out_valid), 64'd0);
      check({tag, " in_ready_after_take"}, 64'(in_ready), 64'd1);
   endtask

   initial begin : stim
      logic [2*W-1:0] e;
      logic [W-1:0]   ra, rb;

      sys_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      #12;
      check("reset in_ready",  64'(in_ready),  64'd1);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset product",   64'(product),   64'd0);
      check("reset state",     64'(dbg_state), 64'd0);
      #1 sys_rst_n = 1'b1;
      step();

      // directed vectors
      run_mult("3x-5", 16'd3, 16'hFFFB, 32'hFFFF_FFF1, LAT_FULL);
      take_output("3x-5");
      run_mult("min x min", 16'h8000, 16'h8000, 32'h4000_0000, LAT_FULL);
      take_output("min x min");
      run_mult("min x max", 16'h8000, 16'h7FFF, 32'hC000_8000, LAT_FULL);
      take_output("min x max");
      run_mult("max x max", 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, LAT_FULL);
      take_output("max x max");
      run_mult("b=0", 16'd1234, 16'd0, 32'h0, LAT_B0);
      take_output("b=0");
      run_mult("100 x -1", 16'd100, 16'hFFFF, 32'hFFFF_FF9C, LAT_BM1);
      take_output("100 x -1");

      // backpressure: the product holds and new operands are ignored
      out_ready = 1'b0;
      run_mult("bp 5x-6", 16'd5, 16'hFFFA, 32'hFFFF_FFE2, LAT_FULL);
      a = 16'd9; b = 16'd9; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp out_valid_hold", 64'(out_valid), 64'd1);
         check("bp product_hold",   64'(product),   64'hFFFF_FFE2);
         check("bp in_ready_low",   64'(in_ready),  64'd0);
      end
      out_ready = 1'b1;
      step();
      check("bp back_to_idle", 64'(in_ready),  64'd1);
      check("bp no_valid",     64'(out_valid), 64'd0);
      step();   // 9x9 is accepted here
      in_valid = 1'b0;
      check("bp accept", 64'(in_ready), 64'd0);
      begin : bp_wait
         int n;
         n = 0;
         while (!out_valid && n < 40) begin
            step();
            n++;
         end
      end
      check("bp 9x9 out_valid", 64'(out_valid), 64'd1);
      check("bp 9x9 product",   64'(product),   64'd81);
      take_output("bp 9x9");

      // asynchronous reset in the middle of RUN
      wait_ready("rst");
      a = 16'd11; b = 16'd13; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step(); step();
      check("rst pre state_run", 64'(dbg_state), 64'd1);
      sys_rst_n = 1'b0;
      #1;
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst product",   64'(product),   64'd0);
      check("rst in_ready",  64'(in_ready),  64'd1);
      #2 sys_rst_n = 1'b1;
      step();
      run_mult("7x9 after rst", 16'd7, 16'd9, 32'd63, LAT_FULL);
      take_output("7x9 after rst");

      // random pairs with idle gaps and output stalls
      for (int i = 0; i < 300; i++) begin
         int hold;
         ra = W'($urandom);
         rb = W'($urandom);
         e  = $signed(ra) * $signed(rb);
         repeat ($urandom_range(0, 2)) step();
         out_ready = 1'b0;
         run_mult("rand", ra, rb, e, LAT_FULL);
         hold = $urandom_range(0, 3);
         for (int k = 0; k < hold; k++) begin
            step();
            check("rand stall product", 64'(product), 64'(e));
         end
         take_output("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
